// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline register with stall/bubble/flush, conflict and stall watchdog.
// Optional performance counters built only when PIPE_REG_PERF_EN is defined.
module pipe_stage_reg #(
    parameter int              WIDTH      = 64,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0,
    parameter int              CNT_W      = 8,
    parameter int              STALL_MAX  = 200,
    parameter int              PERF_W     = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              in_valid_i,
    input  logic [WIDTH-1:0]  in_data_i,
    input  logic              clr_err_i,
    output logic              out_valid_o,
    output logic [WIDTH-1:0]  out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              conflict_o,
    output logic              timeout_o,
    input  logic              perf_clr_i,
    output logic [PERF_W-1:0] perf_stall_o,
    output logic [PERF_W-1:0] perf_bubble_o
);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(STALL_MAX);

    logic             stall_only;
    logic [CNT_W-1:0] cnt_nxt;

    assign stall_only = stall_i & ~bubble_i;
    assign cnt_nxt    = stall_only ? (&stall_cnt_o ? stall_cnt_o : stall_cnt_o + CNT_W'(1)) : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_data_o  <= RESET_VAL;
            out_valid_o <= 1'b0;
            stall_cnt_o <= '0;
            conflict_o  <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            if (bubble_i) begin
                out_data_o  <= BUBBLE_VAL;
                out_valid_o <= 1'b0;
            end else if (!stall_i) begin
                out_data_o  <= in_data_i;
                out_valid_o <= in_valid_i;
            end
            stall_cnt_o <= cnt_nxt;
            // a new set event outranks a simultaneous clear
            conflict_o  <= (stall_i & bubble_i) | (conflict_o & ~clr_err_i);
            timeout_o   <= (cnt_nxt >= MAX_C) | (timeout_o & ~clr_err_i);
        end
    end

`ifdef PIPE_REG_PERF_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            perf_stall_o  <= '0;
            perf_bubble_o <= '0;
        end else if (perf_clr_i) begin
            perf_stall_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            perf_stall_o  <= perf_stall_o + PERF_W'(stall_only);
            perf_bubble_o <= perf_bubble_o + PERF_W'(bubble_i);
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr_i;
    assign perf_stall_o    = '0;
    assign perf_bubble_o   = '0;
`endif
endmodule
